// File: rtl/whack_button_encoder_if.sv
// whack_button_encoder_if: button inputs and encoded outputs of the encoder; WHACK_HIT_COUNT_EN adds hit_count
interface whack_button_encoder_if #(
    parameter int NUM_HOLES = 6
);
    logic [NUM_HOLES-1:0] btn_raw;
    logic [2:0]           input_pos;
    logic                 hit_strobe;
    logic                 multi_err;
    logic [NUM_HOLES-1:0] btn_stable;
`ifdef WHACK_HIT_COUNT_EN
    logic [7:0]           hit_count;
    modport master (output btn_raw, input input_pos, hit_strobe, multi_err, btn_stable, hit_count);
    modport slave (input btn_raw, output input_pos, hit_strobe, multi_err, btn_stable, hit_count);
`else
    modport master (output btn_raw, input input_pos, hit_strobe, multi_err, btn_stable);
    modport slave (input btn_raw, output input_pos, hit_strobe, multi_err, btn_stable);
`endif
endinterface

// File: rtl/whack_button_encoder.sv
// whack_button_encoder: sync + debounce hole buttons, encode a single press to a position code; WHACK_HIT_COUNT_EN adds hit_count
module whack_button_encoder #(
    parameter int NUM_HOLES       = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic CLK100MHZ,
    input logic rst,
    whack_button_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [NUM_HOLES-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [CNT_W-1:0]     cnt_q [NUM_HOLES];
    logic [CNT_W-1:0]     cnt_d [NUM_HOLES];
    state_t               state_q, state_d;
    logic [2:0]           pos_q, pos_d, enc;
    logic                 hit_q, hit_d, err_q, err_d, single;
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_HOLES; i++) begin
            cnt_d[i]    = (sync2_q[i] != stable_q[i] && cnt_q[i] != LAST) ? cnt_q[i] + 1'b1 : '0;
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : stable_q[i];
        end
    end
    // enc is only meaningful when exactly one stable bit is set
    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_HOLES; i++)
            if (stable_q[i]) enc = 3'(i + 1);
        single = stable_q != '0 && (stable_q & (stable_q - 1'b1)) == '0;
    end
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hit_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (single) begin
                    state_d = PRESSED;
                    pos_d   = enc;
                    hit_d   = 1'b1;
                end else if (stable_q != '0) begin
                    state_d = LOCKOUT;
                    err_d   = 1'b1;
                end
            end
            PRESSED: begin
                if (stable_q == '0) begin
                    state_d = IDLE;
                    pos_d   = '0;
                end else if (!(single && enc == pos_q)) begin
                    state_d = LOCKOUT;
                    pos_d   = '0;
                    err_d   = 1'b1;
                end
            end
            LOCKOUT: state_d = (stable_q == '0) ? IDLE : LOCKOUT;
            default: begin
                state_d = IDLE;
                pos_d   = '0;
            end
        endcase
    end
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
            state_q  <= IDLE;
            pos_q    <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= bus.btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pos_q    <= pos_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
        end
    end
    assign bus.input_pos  = pos_q;
    assign bus.hit_strobe = hit_q;
    assign bus.multi_err  = err_q;
    assign bus.btn_stable = stable_q;
`ifdef WHACK_HIT_COUNT_EN
    logic [7:0] hit_cnt_q;
    always_ff @(posedge CLK100MHZ) begin
        if (rst) hit_cnt_q <= '0;
        else hit_cnt_q <= hit_cnt_q + {7'd0, hit_d};
    end
    assign bus.hit_count = hit_cnt_q;
`endif
endmodule
